local_mem_responder: RTL and testbench

//   Synthesizable Avalon-MM responder that emulates one local-memory bank on on-chip RAM.

---
 rtl/local_mem_responder.sv | 147 ++++++++++++++
 tb/tb_local_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_mem_responder.sv
// Avalon-MM responder emulating one local-memory bank in on-chip RAM, with optional
// pseudo-random waitrequest injection for exercising initiator back-pressure paths.
module local_mem_responder #(
  parameter int unsigned DATA_WIDTH       = 512,
  parameter int unsigned ADDR_WIDTH       = 26,
  parameter int unsigned BYTEEN_WIDTH     = 64,
  parameter int unsigned BURSTCOUNT_WIDTH = 7,
  parameter int unsigned DEPTH_LOG2       = 10
) (
  input  logic                        pClk,
  input  logic                        SoftReset_n,
  input  logic [ADDR_WIDTH-1:0]       address,
  input  logic                        read,
  input  logic                        write,
  input  logic [DATA_WIDTH-1:0]       writedata,
  input  logic [BYTEEN_WIDTH-1:0]     byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0] burstcount,
  output logic                        waitrequest,
  output logic [DATA_WIDTH-1:0]       readdata,
  output logic                        readdatavalid,
  input  logic                        stall_en,
  output logic                        busy,
  output logic                        err_sticky
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0]       IdxOne  = 1;
  localparam logic [BURSTCOUNT_WIDTH-1:0] BcOne   = 1;
  localparam logic [15:0]                 LfsrRst = 16'hACE1;

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

  state_e                      state_q, state_d;
  logic [BURSTCOUNT_WIDTH-1:0] rem_q, rem_d;
  logic [DEPTH_LOG2-1:0]       idx_q, idx_d;
  logic                        err_q, err_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic                        rdv_q;
  logic [DATA_WIDTH-1:0]       rdata_q;
  logic [DATA_WIDTH-1:0]       mem_q [Depth];

  logic                        mem_we;
  logic [DEPTH_LOG2-1:0]       mem_waddr;
  logic                        rd_issue;
  logic                        accept;
  logic [DEPTH_LOG2-1:0]       addr_idx;
  logic                        unused_addr;

  assign addr_idx    = address[DEPTH_LOG2-1:0];
  assign unused_addr = ^address[ADDR_WIDTH-1:DEPTH_LOG2];

  // Fibonacci LFSR, taps 16,14,13,11; free-running so stall pattern is independent of traffic.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Reset is folded in combinationally so outputs are quiet during the whole reset cycle.
  assign waitrequest   = ~SoftReset_n | (state_q == StRdBurst) | (stall_en & lfsr_q[0]);
  assign accept        = ~waitrequest;
  assign readdatavalid = SoftReset_n & rdv_q;
  assign readdata      = SoftReset_n ? rdata_q : '0;
  assign busy          = SoftReset_n & (state_q != StIdle);
  assign err_sticky    = SoftReset_n & err_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    rd_issue  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && (read || write)) begin
          if (burstcount == '0) begin
            err_d = 1'b1;
          end else if (write) begin
            mem_we    = 1'b1;
            mem_waddr = addr_idx;
            if (read) err_d = 1'b1;
            if (burstcount > BcOne) begin
              state_d = StWrBurst;
              rem_d   = burstcount - BcOne;
              idx_d   = addr_idx + IdxOne;
            end
          end else begin
            state_d = StRdBurst;
            rem_d   = burstcount;
            idx_d   = addr_idx;
          end
        end
      end
      StWrBurst: begin
        if (read) err_d = 1'b1;
        if (write && accept) begin
          mem_we = 1'b1;
          idx_d  = idx_q + IdxOne;
          rem_d  = rem_q - BcOne;
          if (rem_q == BcOne) state_d = StIdle;
        end
      end
      StRdBurst: begin
        rd_issue = 1'b1;
        idx_d    = idx_q + IdxOne;
        rem_d    = rem_q - BcOne;
        if (rem_q == BcOne) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      lfsr_q  <= LfsrRst;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      lfsr_q  <= lfsr_d;
      rdv_q   <= rd_issue;
    end
  end

  // Registered RAM output; holds between bursts so readdata is stable when not valid.
  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      rdata_q <= '0;
    end else if (rd_issue) begin
      rdata_q <= mem_q[idx_q];
    end
  end

  // RAM array has no reset; contents survive SoftReset_n.
  always_ff @(posedge pClk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BYTEEN_WIDTH); b++) begin
        if (byteenable[b]) mem_q[mem_waddr][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_local_mem_responder.sv
// Scoreboard bench for local_mem_responder: a reference memory predicts read beats and
// their arrival cycles; a negedge monitor pops and compares every readdatavalid beat.
module tb_local_mem_responder;

  localparam int DW = 512;
  localparam int AW = 26;
  localparam int BW = 64;
  localparam int CW = 7;
  localparam int Depth = 1024;

  logic          clk = 1'b0;
  logic          SoftReset_n;
  logic [AW-1:0] address;
  logic          read, write;
  logic [DW-1:0] writedata;
  logic [BW-1:0] byteenable;
  logic [CW-1:0] burstcount;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          stall_en;
  logic          busy;
  logic          err_sticky;

  always #5 clk = ~clk;

  local_mem_responder dut (
    .pClk         (clk),
    .SoftReset_n  (SoftReset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .burstcount   (burstcount),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .stall_en     (stall_en),
    .busy         (busy),
    .err_sticky   (err_sticky)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          ent;
  logic [DW-1:0] model [Depth];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            beats_seen = 0;
  int            wr_toggles = 0;
  logic          wr_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stall_en && (waitrequest !== wr_prev)) wr_toggles++;
    wr_prev = waitrequest;
    if (readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rdv", DW'(1), DW'(0));
      end else begin
        ent = exp_q.pop_front();
        check_eq("rd_data", readdata, ent.data);
        check_eq("rd_cycle", DW'(cyc), DW'(ent.cyc));
        beats_seen++;
      end
    end
  end

  function automatic logic [9:0] idx_of(input logic [AW-1:0] addr, input int beat);
    return addr[9:0] + 10'(beat);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_write(input logic [9:0] idx, input logic [DW-1:0] d,
                                      input logic [BW-1:0] be);
    for (int b = 0; b < BW; b++) if (be[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // Entered and left at posedge+1 with command signals already driven.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!waitrequest) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", DW'(1), DW'(0));
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int bc, input logic [BW-1:0] be,
                          input logic [DW-1:0] d0, input bit rnd);
    bit            ok;
    logic [DW-1:0] d;
    int            nbeats;
    nbeats = (bc == 0) ? 1 : bc;
    for (int i = 0; i < nbeats; i++) begin
      d          = rnd ? rand_word() : (d0 ^ DW'(i));
      write      = 1'b1;
      address    = addr;
      burstcount = CW'(bc);
      writedata  = d;
      byteenable = be;
      wait_accept(ok);
      if (!ok) break;
      if (bc > 0) model_write(idx_of(addr, i), d, be);
    end
    write = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int bc, input bit drain);
    bit   ok;
    exp_t e;
    int   a;
    read       = 1'b1;
    address    = addr;
    burstcount = CW'(bc);
    wait_accept(ok);
    read = 1'b0;
    a    = cyc;
    if (ok) begin
      for (int i = 0; i < bc; i++) begin
        e.data = model[idx_of(addr, i)];
        e.cyc  = a + 1 + i;
        exp_q.push_back(e);
      end
    end
    if (drain) wait_drain();
  endtask

  task automatic apply_reset();
    SoftReset_n = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_waitrequest", DW'(waitrequest), DW'(1));
    check_eq("rst_rdv", DW'(readdatavalid), DW'(0));
    check_eq("rst_readdata", readdata, DW'(0));
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_err", DW'(err_sticky), DW'(0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    SoftReset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;
    SoftReset_n = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    address     = '0;
    writedata   = '0;
    byteenable  = '0;
    burstcount  = '0;
    stall_en    = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Fill RAM so every read has a defined reference value.
    for (int blk = 0; blk < Depth / 64; blk++) do_write(AW'(blk * 64), 64, '1, '0, 1'b1);

    // Single-beat write/read with latency check via rd_cycle.
    do_write(AW'(5), 1, '1, {64{8'hA5}}, 1'b0);
    do_read(AW'(5), 1, 1'b1);

    // Burst wrapping past the top of the RAM.
    do_write(AW'(1022), 4, '1, '0, 1'b1);
    do_read(AW'(1022), 4, 1'b1);

    // Byteenable masking.
    do_write(AW'(300), 1, '1, {64{8'hFF}}, 1'b0);
    do_write(AW'(300), 1, 64'h1, '0, 1'b0);
    do_read(AW'(300), 1, 1'b1);
    check_eq("be_mask_model", model[300], {{63{8'hFF}}, 8'h00});

    // Upper address bits ignored.
    do_write(AW'(26'h3FF_0000 + 26'd77), 2, '1, '0, 1'b1);
    do_read(AW'(77), 2, 1'b1);

    // Protocol errors: read+write together, then a zero-length command.
    read = 1'b1;
    do_write(AW'(10), 1, '1, {64{8'h3C}}, 1'b0);
    read = 1'b0;
    do_read(AW'(11), 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_eq("err_set", DW'(err_sticky), DW'(1));
    check_eq("err_busy", DW'(busy), DW'(0));
    @(posedge clk);
    #1;
    apply_reset();
    @(negedge clk);
    check_eq("err_cleared", DW'(err_sticky), DW'(0));
    @(posedge clk);
    #1;
    do_read(AW'(10), 1, 1'b1);

    // Reset in the middle of a 6-beat read.
    do_write(AW'(100), 6, '1, '0, 1'b1);
    base = beats_seen;
    do_read(AW'(100), 6, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      #1;
      if (beats_seen >= base + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("mid_burst_beats", DW'(ok), DW'(1));
    @(posedge clk);
    #1;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_rdv", DW'(readdatavalid), DW'(0));
      check_eq("post_rst_busy", DW'(busy), DW'(0));
    end
    @(posedge clk);
    #1;
    do_write(AW'(200), 3, '1, '0, 1'b1);
    do_read(AW'(200), 3, 1'b1);

    // Random bursts under random waitrequest.
    stall_en = 1'b1;
    for (int t = 0; t < 100; t++) begin
      logic [AW-1:0] ra;
      int            rb;
      ra = AW'($urandom);
      rb = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, rb, BW'({$urandom, $urandom}), '0, 1'b1);
      end else begin
        do_read(ra, rb, 1'b1);
      end
    end
    check_eq("wr_toggles", DW'(wr_toggles > 10), DW'(1));
    check_eq("final_err", DW'(err_sticky), DW'(0));
    stall_en = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
